// File: rtl/isa_read_responder_if.sv
`default_nettype none
// ============================================================================
// isa_read_responder_if : cache-side fetch and DDR burst-read signal bundle
// Rev 1.0
// ============================================================================
interface isa_read_responder_if #(
  parameter int ISA_WIDTH      = 30,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64
);

  // Instruction-cache side
  logic                      ISA_read_req;
  logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr;
  logic [9:0]                isa_read_len;
  logic [ISA_WIDTH-1:0]      instruction_to_cache;
  logic [9:0]                rd_cnt_isa;
  logic                      rd_burst_data_valid;
  logic                      ddr_rdy;
  logic [3:0]                state_interface_module;
  logic                      isa_short_err;

  // DDR controller side
  logic                      rd_burst_req;
  logic [DDR_ADDR_WIDTH-1:0] rd_burst_addr;
  logic [9:0]                rd_burst_len;
  logic                      ddr_rd_data_valid;
  logic [DDR_DATA_WIDTH-1:0] ddr_rd_data;
  logic                      rd_burst_finish;

  // Environment view: cache requester plus DDR controller
  modport master (
    output ISA_read_req,
    output ISA_read_addr,
    output isa_read_len,
    input  instruction_to_cache,
    input  rd_cnt_isa,
    input  rd_burst_data_valid,
    input  ddr_rdy,
    input  state_interface_module,
    input  isa_short_err,
    input  rd_burst_req,
    input  rd_burst_addr,
    input  rd_burst_len,
    output ddr_rd_data_valid,
    output ddr_rd_data,
    output rd_burst_finish
  );

  // Responder view
  modport slave (
    input  ISA_read_req,
    input  ISA_read_addr,
    input  isa_read_len,
    output instruction_to_cache,
    output rd_cnt_isa,
    output rd_burst_data_valid,
    output ddr_rdy,
    output state_interface_module,
    output isa_short_err,
    output rd_burst_req,
    output rd_burst_addr,
    output rd_burst_len,
    input  ddr_rd_data_valid,
    input  ddr_rd_data,
    input  rd_burst_finish
  );

endinterface
`default_nettype wire

// File: rtl/isa_read_responder.sv
`default_nettype none
// ============================================================================
// isa_read_responder : turns an instruction-fetch request into one DDR burst
// read and streams the returned words to the instruction cache.
// Rev 1.0
// ============================================================================
module isa_read_responder #(
  parameter int ISA_WIDTH      = 30,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int DDR_DATA_WIDTH = 64,
  parameter int MAX_BURST      = 128
) (
  input  wire logic           clk,
  input  wire logic           rst,
  isa_read_responder_if.slave bus
);

  localparam logic [9:0] MAX_LEN = 10'(MAX_BURST);

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    MEM_READ_ISA = 4'd5,
    ISA_DONE     = 4'd6
  } state_t;

  state_t                    state;
  state_t                    state_next;

  logic [DDR_ADDR_WIDTH-1:0] burst_addr;
  logic [9:0]                burst_len;
  logic [9:0]                cnt;
  logic [9:0]                cnt_next;
  logic [9:0]                eff_len;
  logic [ISA_WIDTH-1:0]      instr;
  logic                      data_valid;
  logic                      short_err;

  logic                      accept;
  logic                      beat_take;
  logic                      burst_end;

  always_comb begin
    eff_len   = (bus.isa_read_len > MAX_LEN) ? MAX_LEN : bus.isa_read_len;
    accept    = (state == IDLE) && bus.ISA_read_req && (bus.isa_read_len != 10'd0);
    // Beats beyond the requested length are dropped so the count never exceeds L
    beat_take = (state == MEM_READ_ISA) && bus.ddr_rd_data_valid && (cnt < burst_len);
    burst_end = (state == MEM_READ_ISA) && bus.rd_burst_finish;
    cnt_next  = cnt + {9'd0, beat_take};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = MEM_READ_ISA;
        end
      end
      MEM_READ_ISA: begin
        if (bus.rd_burst_finish) begin
          state_next = ISA_DONE;
        end
      end
      ISA_DONE: begin
        if (!bus.ISA_read_req) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_addr <= '0;
      burst_len  <= 10'd0;
      cnt        <= 10'd0;
      instr      <= '0;
      data_valid <= 1'b0;
      short_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (accept) begin
        burst_addr <= bus.ISA_read_addr;
        burst_len  <= eff_len;
        cnt        <= 10'd0;
        short_err  <= 1'b0;
      end
      if (beat_take) begin
        instr      <= bus.ddr_rd_data[ISA_WIDTH-1:0];
        cnt        <= cnt_next;
        data_valid <= 1'b1;
      end
      // A beat landing with the finish pulse is already folded into cnt_next
      if (burst_end && (cnt_next < burst_len)) begin
        short_err <= 1'b1;
      end
    end
  end

  // Upper DDR bits carry nothing for the instruction path
  generate
    if (DDR_DATA_WIDTH > ISA_WIDTH) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^bus.ddr_rd_data[DDR_DATA_WIDTH-1:ISA_WIDTH];
    end
  endgenerate

  assign bus.ddr_rdy                = (state == IDLE);
  assign bus.rd_burst_req           = (state == MEM_READ_ISA);
  assign bus.rd_burst_addr          = burst_addr;
  assign bus.rd_burst_len           = burst_len;
  assign bus.instruction_to_cache   = instr;
  assign bus.rd_cnt_isa             = cnt;
  assign bus.rd_burst_data_valid    = data_valid;
  assign bus.isa_short_err          = short_err;
  assign bus.state_interface_module = state;

endmodule
`default_nettype wire

// File: doc/isa_read_responder.md
ISA_READ_RESPONDER -- requirements
Module: isa_read_responder

Interface
REQ-001 Parameter ISA_WIDTH, default 30: instruction word width (OPCODE 4 + CAM addr 8 + operand-2 2 + MEM addr 16).
REQ-002 Parameter DDR_ADDR_WIDTH, default 28: DDR byte address width.
REQ-003 Parameter DDR_DATA_WIDTH, default 64: DDR burst data width; one instruction per DDR word, 8-byte stride.
REQ-004 Parameter MAX_BURST, default 128: largest burst length accepted.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 ISA_read_req  in  1  instruction-fetch request from the instruction cache, level, held until completion is seen.
REQ-008 ISA_read_addr  in  DDR_ADDR_WIDTH  DDR byte address of the first instruction.
REQ-009 isa_read_len  in  10  number of instructions requested.
REQ-010 instruction_to_cache  out  ISA_WIDTH  returned instruction word.
REQ-011 rd_cnt_isa  out  10  count of instructions delivered in the current burst.
REQ-012 rd_burst_data_valid  out  1  one-cycle strobe, instruction_to_cache and rd_cnt_isa updated this cycle.
REQ-013 ddr_rdy  out  1  responder idle and able to accept a request.
REQ-014 state_interface_module  out  4  current state encoding.
REQ-015 isa_short_err  out  1  sticky: last burst finished with fewer beats than requested.
REQ-016 rd_burst_req  out  1  DDR burst read request, level.
REQ-017 rd_burst_addr  out  DDR_ADDR_WIDTH  DDR burst start address.
REQ-018 rd_burst_len  out  10  DDR burst length in words.
REQ-019 ddr_rd_data_valid  in  1  DDR read beat valid.
REQ-020 ddr_rd_data  in  DDR_DATA_WIDTH  DDR read beat.
REQ-021 rd_burst_finish  in  1  one-cycle pulse, DDR burst complete.

Function
REQ-022 States SHALL be IDLE=4'd0, MEM_READ_ISA=4'd5, ISA_DONE=4'd6; state_interface_module SHALL equal the registered state.
REQ-023 IDLE: ddr_rdy=1, rd_burst_req=0; on ISA_read_req=1 with isa_read_len!=0, latch addr and effective length L=min(isa_read_len, MAX_BURST), clear rd_cnt_isa and isa_short_err, go MEM_READ_ISA next cycle.
REQ-024 ISA_read_req=1 with isa_read_len=0 SHALL be ignored; the block stays in IDLE.
REQ-025 MEM_READ_ISA: ddr_rdy=0, rd_burst_req=1, rd_burst_addr=latched addr, rd_burst_len=L, all held constant for the whole state.
REQ-026 Each ddr_rd_data_valid beat with rd_cnt_isa<L SHALL, one cycle later, present instruction_to_cache=ddr_rd_data[ISA_WIDTH-1:0], rd_cnt_isa incremented by 1, and rd_burst_data_valid=1 for that single cycle.
REQ-027 Beats arriving when rd_cnt_isa already equals L SHALL be discarded: no strobe, no count change.
REQ-028 On rd_burst_finish, go ISA_DONE and drop rd_burst_req the next cycle; a beat valid in the same cycle as finish SHALL still be delivered and counted.
REQ-029 If rd_cnt_isa (including any same-cycle beat) is below L at finish, isa_short_err SHALL be set.
REQ-030 ISA_DONE: rd_burst_req=0, ddr_rdy=0, rd_cnt_isa and instruction_to_cache held; return to IDLE when ISA_read_req=0.
REQ-031 If ISA_read_req drops during MEM_READ_ISA, the burst SHALL run to rd_burst_finish with data still delivered, then ISA_DONE, then IDLE.
REQ-032 rd_cnt_isa SHALL hold its final value through ISA_DONE and IDLE until the next accepted request.
REQ-033 No counter SHALL wrap: rd_cnt_isa is bounded by L<=MAX_BURST<1024.

Reset
REQ-034 While rst=1, asynchronously: state IDLE; rd_burst_req=0, rd_burst_addr=0, rd_burst_len=0, instruction_to_cache=0, rd_cnt_isa=0, rd_burst_data_valid=0, isa_short_err=0, ddr_rdy=1.
REQ-035 Reset asserted mid-burst SHALL abandon the burst; beats arriving after release in IDLE SHALL be ignored.

Verification
REQ-036 req, addr=0x40, len=4; DDR returns 4 beats then finish -> rd_burst_addr=0x40, rd_burst_len=4; four strobes with rd_cnt_isa 1,2,3,4, words equal to low 30 bits of beats; ISA_DONE; IDLE after req drops.
REQ-037 len=200 -> rd_burst_len=128; 128 strobes; rd_cnt_isa ends at 128; isa_short_err=0.
REQ-038 len=4, DDR sends 6 beats -> only 4 strobes; rd_cnt_isa=4.
REQ-039 len=4, finish after 2 beats -> rd_cnt_isa=2, isa_short_err=1; cleared on next accepted request.
REQ-040 Final beat coincident with finish -> delivered, rd_cnt_isa=L, isa_short_err=0; len=0 request -> no rd_burst_req.
REQ-041 rst pulse after 2 of 8 beats -> all outputs at reset values immediately; state IDLE; later beats ignored.
